ahb_rr_arbiter: RTL and testbench

- AHB bus arbiter for the shared address/control/write-data path between up to four masters.
- Registers one-hot hgrant and drives hmaster/hmastlock, which select the master-side multiplexor and reach the slaves.
- Round-robin fairness; holds the grant for fixed-length bursts, undefined-length INCR and locked sequences.
- Honours SPLIT masking when compiled in.

---
 rtl/ahb_rr_arbiter_if.sv | 28 ++
 rtl/ahb_rr_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_rr_arbiter_if.sv
// rtl/ahb_rr_arbiter_if.sv - request/grant bundle between AHB masters and the arbiter
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = 2
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [1:0]             hresp;
  logic [15:0]            hsplit;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MIDX_W-1:0]      hmaster;
  logic                   hmastlock;

  // Bus side: masters, muxes and slaves driving the arbiter
  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
    input  hgrant, hmaster, hmastlock
  );

  // Arbiter side
  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin AHB arbiter with burst/lock hold; SPLIT masking under AHB_ARB_SPLIT_EN
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = 2
) (
  input logic             hclk,
  input logic             hreset_n,
  ahb_rr_arbiter_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_UNDEF  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MIDX_W-1:0]      hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MIDX_W-1:0]      rr_q, rr_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   term_q, term_d;

  logic [MIDX_W-1:0]      owner_idx;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   owner_drives;
  logic [3:0]             burst_len;
  logic                   hold;

  logic [NUM_MASTERS-1:0] req_eff;
  logic [MIDX_W:0]        scan_sum;
  logic [MIDX_W-1:0]      scan_idx;
  logic [MIDX_W-1:0]      win_idx;
  logic                   win_found;

  logic                   unused_hsplit;
  assign unused_hsplit = ^bus.hsplit;

  // Decode the one-hot grant into the owner index and its request/lock lines
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant_q[i]) owner_idx = MIDX_W'(i);
    end
    owner_req    = bus.hbusreq[owner_idx];
    owner_lock   = bus.hlock[owner_idx];
    // Burst starts only count when the granted master already owns the address phase
    owner_drives = (hmaster_q == owner_idx);
  end

  // Beats remaining after the first beat of a fixed-length burst (0 = not fixed-length)
  always_comb begin
    burst_len = 4'd0;
    case (bus.hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 4'd15;
      default:                      burst_len = 4'd0;
    endcase
  end

  // Round-robin scan from the pointer + 1, skipping masked masters; default master 0
  always_comb begin
    req_eff   = bus.hbusreq & ~mask_q;
    win_idx   = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      scan_sum = {1'b0, rr_q} + (MIDX_W+1)'(i);
      if (scan_sum >= (MIDX_W+1)'(NUM_MASTERS)) begin
        scan_sum = scan_sum - (MIDX_W+1)'(NUM_MASTERS);
      end
      scan_idx = scan_sum[MIDX_W-1:0];
      if (!win_found && req_eff[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  // SPLIT masks the current address-phase master; a resume bit clears it and wins over a set
  always_comb begin
    mask_d = mask_q;
    if (!bus.hready && bus.hresp == HRESP_SPLIT) begin
      mask_d[hmaster_q] = 1'b1;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (bus.hsplit[i]) mask_d[i] = 1'b0;
    end
    mask_d[0] = 1'b0;
  end
`else
  // Without SPLIT support nobody is ever excluded from arbitration
  always_comb begin
    mask_d = '0;
  end
`endif

  // State register: all arbiter state, synchronous active-low reset
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q     <= ST_FREE;
      hgrant_q    <= NUM_MASTERS'(1);
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
      cnt_q       <= 4'd0;
      rr_q        <= MIDX_W'(NUM_MASTERS - 1);
      mask_q      <= '0;
      term_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      mask_q      <= mask_d;
      term_q      <= term_d;
    end
  end

  // Next state: decide whether the owner keeps the bus across this ready edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    hold    = 1'b0;
    if (bus.hready) begin
      term_d = 1'b0;
      if (owner_lock) begin
        // A locked owner keeps the bus regardless of any burst bookkeeping
        state_d = ST_LOCKED;
        hold    = 1'b1;
      end else begin
        case (state_q)
          ST_BURST: begin
            if (term_q || bus.htrans == HTRANS_IDLE) begin
              state_d = ST_FREE;
              cnt_d   = 4'd0;
            end else if (bus.htrans == HTRANS_SEQ) begin
              cnt_d = cnt_q - 4'd1;
              // Counter reaching 1 frees the bus so the next owner is granted during the last beat
              if (cnt_q <= 4'd2) begin
                state_d = ST_FREE;
              end else begin
                hold = 1'b1;
              end
            end else begin
              hold = 1'b1;
            end
          end
          ST_UNDEF: begin
            if (term_q || bus.htrans == HTRANS_IDLE || !owner_req) begin
              state_d = ST_FREE;
            end else begin
              hold = 1'b1;
            end
          end
          default: begin
            state_d = ST_FREE;
            if (owner_drives && bus.htrans == HTRANS_NONSEQ) begin
              if (burst_len != 4'd0) begin
                state_d = ST_BURST;
                cnt_d   = burst_len;
                hold    = 1'b1;
              end else if (bus.hburst == HBURST_INCR && owner_req) begin
                state_d = ST_UNDEF;
                hold    = 1'b1;
              end
            end
          end
        endcase
      end
    end else if (bus.hresp != HRESP_OKAY) begin
      // First cycle of a two-cycle response: abandon the burst at the next ready edge
      term_d = 1'b1;
      cnt_d  = 4'd0;
    end
  end

  // Outputs: grant/master/lock only move on ready edges; pointer follows grant changes
  always_comb begin
    hgrant_d    = hgrant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    rr_d        = rr_q;
    if (bus.hready) begin
      hmaster_d   = owner_idx;
      hmastlock_d = owner_lock;
      if (!hold && win_idx != owner_idx) begin
        hgrant_d          = '0;
        hgrant_d[win_idx] = 1'b1;
        rr_d              = win_idx;
      end
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb/tb_ahb_rr_arbiter.sv - directed vector bench for ahb_rr_arbiter
module tb_ahb_rr_arbiter;

  localparam int NM = 4;
  localparam int MW = 2;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;

  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_ERROR = 2'b01;
  localparam logic [1:0] R_SPLIT = 2'b11;

  logic hclk = 1'b0;
  logic hreset_n;

  always #5 hclk = ~hclk;

  ahb_rr_arbiter_if #(.NUM_MASTERS(NM), .MIDX_W(MW)) bus ();

  ahb_rr_arbiter #(.NUM_MASTERS(NM), .MIDX_W(MW)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] exp_grant;
    logic [1:0] exp_master;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[18];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                        input logic [2:0] burst, input logic ready, input logic [1:0] resp,
                        input logic [15:0] split);
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.htrans  = trans;
    bus.hburst  = burst;
    bus.hready  = ready;
    bus.hresp   = resp;
    bus.hsplit  = split;
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] m, input logic l);
    check($sformatf("%s hgrant", name), 32'(bus.hgrant), 32'(g));
    check($sformatf("%s hmaster", name), 32'(bus.hmaster), 32'(m));
    check($sformatf("%s hmastlock", name), 32'(bus.hmastlock), 32'(l));
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                              input logic [2:0] burst, input logic ready, input logic [3:0] g,
                              input logic [1:0] m, input logic l);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.ready = ready;
    v.exp_grant = g; v.exp_master = m; v.exp_lock = l;
    return v;
  endfunction

  initial begin
    logic [1:0] burst_tr [8];
    logic [3:0] burst_gr [8];

    // idle after reset: default master keeps the bus
    vecs[0]  = mk(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
    vecs[1]  = mk(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
    vecs[2]  = mk(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
    // masters 1 and 2 with SINGLE transfers alternate; hmaster lags
    vecs[3]  = mk(4'b0110, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
    vecs[4]  = mk(4'b0110, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
    vecs[5]  = mk(4'b0110, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd2, 1'b0);
    vecs[6]  = mk(4'b0110, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
    // wait state freezes everything
    vecs[7]  = mk(4'b0110, 4'b0000, T_NSEQ, B_SINGLE, 1'b0, 4'b0100, 2'd1, 1'b0);
    vecs[8]  = mk(4'b0110, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd2, 1'b0);
    // no requests -> default master; then 0 and 3 alternate with wrap
    vecs[9]  = mk(4'b0000, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd1, 1'b0);
    vecs[10] = mk(4'b1001, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd0, 1'b0);
    vecs[11] = mk(4'b1001, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);
    vecs[12] = mk(4'b1001, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd0, 1'b0);
    // master 3 locked while master 1 waits
    vecs[13] = mk(4'b1010, 4'b1000, T_NSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd3, 1'b1);
    vecs[14] = mk(4'b1010, 4'b1000, T_NSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd3, 1'b1);
    vecs[15] = mk(4'b1010, 4'b1000, T_NSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd3, 1'b1);
    vecs[16] = mk(4'b0010, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd3, 1'b0);
    vecs[17] = mk(4'b0010, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0);

    // reset
    hreset_n = 1'b0;
    set_in(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 16'h0000);
    tick();
    tick();
    expect_out("reset", 4'b0001, 2'd0, 1'b0);
    hreset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    expect_out("idle10", 4'b0001, 2'd0, 1'b0);

    // table
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].req, vecs[i].lock, vecs[i].trans, vecs[i].burst, vecs[i].ready, R_OKAY, 16'h0000);
      tick();
      expect_out($sformatf("vec[%0d]", i), vecs[i].exp_grant, vecs[i].exp_master, vecs[i].exp_lock);
    end

    // INCR8 by master 2 with one BUSY, master 1 waiting
    set_in(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("incr8 grant", 4'b0100, 2'd1, 1'b0);
    tick();
    expect_out("incr8 own", 4'b0100, 2'd2, 1'b0);
    burst_tr = '{T_NSEQ, T_SEQ, T_SEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_SEQ};
    burst_gr = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      set_in(4'b0110, 4'b0000, burst_tr[i], B_INCR8, 1'b1, R_OKAY, 16'h0000);
      tick();
      expect_out($sformatf("incr8 edge%0d", i), burst_gr[i], 2'd2, 1'b0);
    end
    set_in(4'b0010, 4'b0000, T_SEQ, B_INCR8, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("incr8 beat8", 4'b0010, 2'd1, 1'b0);

    // SPLIT response to master 1
    set_in(4'b0010, 4'b0000, T_NSEQ, B_SINGLE, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("split pre", 4'b0010, 2'd1, 1'b0);
    set_in(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b0, R_SPLIT, 16'h0000);
    tick();
    expect_out("split resp1", 4'b0010, 2'd1, 1'b0);
    set_in(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_SPLIT, 16'h0000);
    tick();
`ifdef AHB_ARB_SPLIT_EN
    expect_out("split resp2", 4'b0001, 2'd1, 1'b0);
`else
    expect_out("split resp2", 4'b0010, 2'd1, 1'b0);
`endif
    set_in(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 16'h0002);
    tick();
`ifdef AHB_ARB_SPLIT_EN
    expect_out("split resume", 4'b0001, 2'd0, 1'b0);
`else
    expect_out("split resume", 4'b0010, 2'd1, 1'b0);
`endif
    set_in(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 16'h0000);
    tick();
`ifdef AHB_ARB_SPLIT_EN
    expect_out("split regrant", 4'b0010, 2'd0, 1'b0);
`else
    expect_out("split regrant", 4'b0010, 2'd1, 1'b0);
`endif
    tick();
    expect_out("split settle", 4'b0010, 2'd1, 1'b0);

    // INCR4 terminated by ERROR; BUSY after the response must not keep the hold
    set_in(4'b0011, 4'b0000, T_NSEQ, B_INCR4, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("err start", 4'b0010, 2'd1, 1'b0);
    set_in(4'b0011, 4'b0000, T_BUSY, B_INCR4, 1'b0, R_ERROR, 16'h0000);
    tick();
    expect_out("err resp1", 4'b0010, 2'd1, 1'b0);
    set_in(4'b0011, 4'b0000, T_BUSY, B_INCR4, 1'b1, R_ERROR, 16'h0000);
    tick();
    expect_out("err resp2", 4'b0001, 2'd1, 1'b0);
    set_in(4'b0001, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("err settle", 4'b0001, 2'd0, 1'b0);

    // undefined-length INCR held while master 0 requests
    set_in(4'b0011, 4'b0000, T_NSEQ, B_INCR, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("undef start", 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      set_in(4'b0011, 4'b0000, T_SEQ, B_INCR, 1'b1, R_OKAY, 16'h0000);
      tick();
      expect_out($sformatf("undef hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    set_in(4'b0010, 4'b0000, T_SEQ, B_INCR, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("undef release", 4'b0010, 2'd0, 1'b0);

    // reset in beat 5 of an INCR16 by master 1
    set_in(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("incr16 own", 4'b0010, 2'd1, 1'b0);
    set_in(4'b0110, 4'b0000, T_NSEQ, B_INCR16, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("incr16 beat1", 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_in(4'b0110, 4'b0000, T_SEQ, B_INCR16, 1'b1, R_OKAY, 16'h0000);
      tick();
      expect_out($sformatf("incr16 beat%0d", i + 2), 4'b0010, 2'd1, 1'b0);
    end
    hreset_n = 1'b0;
    tick();
    expect_out("incr16 reset", 4'b0001, 2'd0, 1'b0);
    check("incr16 reset cnt", 32'(dut.cnt_q), 32'd0);
    check("incr16 reset state", 32'(dut.state_q), 32'd0);
    hreset_n = 1'b1;
    set_in(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OKAY, 16'h0000);
    tick();
    expect_out("post reset arb", 4'b0100, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
